// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, trap cause codes,
// status/enable bit positions and the CSR access opcodes.
package csr_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [3:0] ECALL_M   = 4'd11;
  localparam logic [3:0] BREAK     = 4'd3;
  localparam logic [3:0] ILLEGAL   = 4'd2;
  localparam logic [3:0] IRQ_EXT   = 4'd11;
  localparam logic [3:0] IRQ_SW    = 4'd3;
  localparam logic [3:0] IRQ_TIMER = 4'd7;

  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;
  localparam int unsigned MSIE_BIT = 3;
  localparam int unsigned MTIE_BIT = 7;
  localparam int unsigned MEIE_BIT = 11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  typedef enum logic [1:0] {
    CSR_WR  = 2'b01,
    CSR_SET = 2'b10,
    CSR_CLR = 2'b11
  } csr_op_e;

  // MPP is hard-wired to machine mode.
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v           = '0;
    v[12:11]    = 2'b11;
    v[MPIE_BIT] = mpie;
    v[MIE_BIT]  = mie;
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter whose halves can be loaded independently by CSR writes.
module csr_counter64 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_q, count_d;

  // A write to one half replaces this cycle's increment; the other half holds.
  always_comb begin
    count_d = count_q;
    if (wr_lo) begin
      count_d[31:0] = wdata;
    end else if (wr_hi) begin
      count_d[63:32] = wdata;
    end else if (inc) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller: CSR read/write, exception and
// interrupt entry, mret, and the mcycle/minstret counters.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter logic [31:0] HARTID    = 32'h0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_1104,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] csr_rd_index,
  output logic [31:0] csr_rdat,
  input  logic        csr_wr_en,
  input  logic [11:0] csr_wr_index,
  input  logic [31:0] csr_wdata,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_exp,
  input  logic        ex_e_ecfm,
  input  logic        ex_e_bk,
  input  logic        ex_mret,
  input  logic        instret,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  output logic        trap_flush,
  output logic [31:0] trap_target,
  output logic        csr_illegal
);

  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic        flush_q, flush_d;
  logic [31:0] target_q, target_d;
  logic [63:0] mcycle, minstret;
  logic [31:0] mip, pend;
  logic        irq_pend, take_exc, take_irq, take_mret, wr_ok, byp;
  logic [3:0]  irq_code, exc_code;

  assign mip      = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  assign pend     = mip & mie_q;
  assign irq_pend = mst_mie_q & (|pend) & ex_valid;

  // The slot behind a flush is being squashed, so nothing in it may act.
  assign take_exc  = ~flush_q & ex_exp;
  assign take_irq  = ~flush_q & ~take_exc & irq_pend;
  assign take_mret = ~flush_q & ~take_exc & ~take_irq & ex_mret;
  assign wr_ok     = ~flush_q & ~take_exc & ~take_irq & csr_wr_en;

  always_comb begin
    if (pend[MEIE_BIT]) irq_code = IRQ_EXT;
    else if (pend[MSIE_BIT]) irq_code = IRQ_SW;
    else irq_code = IRQ_TIMER;
    if (ex_e_ecfm) exc_code = ECALL_M;
    else if (ex_e_bk) exc_code = BREAK;
    else exc_code = ILLEGAL;
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (wr_ok) begin
      case (csr_wr_index)
        CSR_MSTATUS: begin
          mst_mie_d  = csr_wdata[MIE_BIT];
          mst_mpie_d = csr_wdata[MPIE_BIT];
        end
        CSR_MIE:      mie_d      = csr_wdata & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = csr_wdata & ~32'h3;
        CSR_MSCRATCH: mscratch_d = csr_wdata;
        CSR_MEPC:     mepc_d     = csr_wdata & ~32'h1;
        CSR_MCAUSE:   mcause_d   = csr_wdata;
        CSR_MTVAL:    mtval_d    = csr_wdata;
        default: ;
      endcase
    end
    // Trap updates are applied last so they win over a same-cycle write.
    if (take_exc || take_irq) begin
      mepc_d     = ex_pc & ~32'h1;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      mtval_d    = '0;
      mcause_d   = take_exc ? {28'b0, exc_code} : {1'b1, 27'b0, irq_code};
    end else if (take_mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
    flush_d  = take_exc | take_irq | take_mret;
    target_d = target_q;
    if (take_exc || take_irq) target_d = mtvec_q;
    else if (take_mret) target_d = mepc_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST & ~32'h3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      flush_q    <= 1'b0;
      target_q   <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      flush_q    <= flush_d;
      target_q   <= target_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (1'b1),
    .wr_lo (wr_ok && csr_wr_index == CSR_MCYCLE),
    .wr_hi (wr_ok && csr_wr_index == CSR_MCYCLEH),
    .wdata (csr_wdata),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (instret & ~take_irq),
    .wr_lo (wr_ok && csr_wr_index == CSR_MINSTRET),
    .wr_hi (wr_ok && csr_wr_index == CSR_MINSTRETH),
    .wdata (csr_wdata),
    .count (minstret)
  );

  // Read port with bypass of a same-cycle write to the same index.
  always_comb begin
    byp         = wr_ok && (csr_wr_index == csr_rd_index);
    csr_rdat    = '0;
    csr_illegal = 1'b0;
    case (csr_rd_index)
      CSR_MSTATUS:   csr_rdat = byp ? mstatus_pack(csr_wdata[MIE_BIT], csr_wdata[MPIE_BIT])
                                    : mstatus_pack(mst_mie_q, mst_mpie_q);
      CSR_MISA:      csr_rdat = MISA_VAL;
      CSR_MIE:       csr_rdat = byp ? (csr_wdata & MIE_MASK) : mie_q;
      CSR_MTVEC:     csr_rdat = byp ? (csr_wdata & ~32'h3) : mtvec_q;
      CSR_MSCRATCH:  csr_rdat = byp ? csr_wdata : mscratch_q;
      CSR_MEPC:      csr_rdat = byp ? (csr_wdata & ~32'h1) : mepc_q;
      CSR_MCAUSE:    csr_rdat = byp ? csr_wdata : mcause_q;
      CSR_MTVAL:     csr_rdat = byp ? csr_wdata : mtval_q;
      CSR_MIP:       csr_rdat = mip;
      CSR_MCYCLE:    csr_rdat = byp ? csr_wdata : mcycle[31:0];
      CSR_MCYCLEH:   csr_rdat = byp ? csr_wdata : mcycle[63:32];
      CSR_MINSTRET:  csr_rdat = byp ? csr_wdata : minstret[31:0];
      CSR_MINSTRETH: csr_rdat = byp ? csr_wdata : minstret[63:32];
      CSR_MHARTID:   csr_rdat = HARTID;
      default:       csr_illegal = 1'b1;
    endcase
  end

  assign trap_flush  = flush_q;
  assign trap_target = target_q;

endmodule
